vector_store_sequencer: RTL and testbench
=========================================

// Module: vector_store_sequencer
// PURPOSE
//   Sequences vector and scalar store instructions onto the single data-memory write port.
//   - Accepts one store request at a time through a valid/ready handshake and latches its operands.
//   - Emits one write per cycle: I writes for a vector store, 1 for a scalar store.
//   - Honours a memory back-pressure signal and pulses done when the store retires.
//   - Sits between the execute stage and data memory; it replaces free-running counter-based write sequencing.
// PARAMETERS
//   I  20  number of items per vector
//   L  32  item width in bits
//   A  10  memory address width in bits
// PORTS
//   clk              in   1    clock; all state updates on rising edge
//   rst              in   1    synchronous reset, active-high
//   req_valid        in   1    store request present
//   req_ready        out  1    sequencer can accept a request
//   req_vector       in   1    1 = vector store, 0 = scalar store
//   req_base_addr    in   A    base write address
//   req_vector_data  in   I*L  vector operand; item k = bits [k*L +: L]
//   req_scalar_data  in   L    scalar operand
//   mem_ready        in   1    memory accepts the write presented this cycle
//   mem_we           out  1    write enable
//   mem_addr         out  A    write address
//   mem_wdata        out  L    write data
//   busy             out  1    transfer in progress (state != IDLE)
//   done             out  1    one-cycle pulse, store retired
// BEHAVIOUR
//   Reset and output timing
//   - rst has priority over every other input. Next state is IDLE, idx = 0, operand regs = 0.
//   - Reset output values: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
//   - All outputs decode from registers only; there is no combinational path from any input to any output.
//   FSM states
//   - IDLE: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
//     On req_valid & req_ready: latch req_vector, req_base_addr and the operands; set idx=0; go to WRITE.
//   - WRITE: mem_we=1 and mem_addr = (base + idx) mod 2^A (A-bit wrap, no carry out).
//     mem_wdata = item idx for a vector store, or the latched scalar for a scalar store.
//     - If mem_ready and this is the last write (idx==I-1 for vector; always for scalar): go to DONE.
//     - If mem_ready and not the last write: idx += 1.
//     - If !mem_ready: idx and state hold, and mem_addr/mem_wdata stay stable.
//   - DONE: done=1 and mem_we=0 for exactly one cycle, then go to IDLE.
//   Other rules
//   - req_ready is 0 in WRITE and DONE; req_valid is ignored outside IDLE.
//   - Request inputs may change freely after acceptance; only the latched copies are used.
//   - Latency with no stalls (request accepted at edge t):
//     - first write visible in cycle t+1;
//     - vector writes occupy t+1..t+I and scalar write occupies t+1;
//     - done in t+I+1 (vector) or t+2 (scalar); req_ready high again the cycle after done.
//   - Each stall cycle extends everything after it by one cycle. Total writes always = I or 1, never repeated or skipped.
//   - Address wrap: base=2^A-3 with I=20 writes 1021,1022,1023,0,1,...,16.
//   - rst during WRITE abandons the transfer. mem_we is 0 from the next cycle, no done is pulsed, and partial writes are not undone.
//   - rst asserted in the same cycle as an accepted request: rst wins and the request is dropped.
// TESTING
//   - After reset: req_ready=1, busy=0, mem_we=0, done=0; hold req_valid=0 for 5 cycles -> no write, no done.
//   - Scalar store: base=0x12, scalar=0xDEADBEEF, mem_ready=1 -> one write addr 0x12 data 0xDEADBEEF, done 1 cycle later.
//   - Vector store: base=100, item k=k+1, mem_ready=1 -> 20 consecutive writes, addr 100..119, data 1..20; done in cycle t+21.
//   - Back-pressure: vector store with mem_ready=0 on writes 0 and 7 for 3 cycles each -> addr/data held, 20 unique writes, done at t+27.
//   - Wrap: base=1021, vector store -> addresses 1021..1023, then 0..16; req_valid pulsed during WRITE is ignored.
//   - Reset mid-vector after 5 writes -> mem_we=0 the next cycle, no done, req_ready=1; new scalar store then completes normally.

Source files
------------

// File: rtl/vector_store_sequencer_if.sv
// vector_store_sequencer_if: request and memory-write bundle for the store sequencer
//   req_valid/req_ready    request handshake (execute -> sequencer)
//   req_vector             1 = vector store, 0 = scalar store
//   req_base_addr          base write address (A bits)
//   req_vector_data        vector operand, item k = bits [k*L +: L]
//   req_scalar_data        scalar operand (L bits)
//   mem_ready              memory accepts the write presented this cycle
//   mem_we/addr/wdata      memory write port
//   busy                   transfer in progress
//   done                   one-cycle retire pulse
interface vector_store_sequencer_if #(
    parameter int I = 20,
    parameter int L = 32,
    parameter int A = 10
);
    logic             req_valid;
    logic             req_ready;
    logic             req_vector;
    logic [A-1:0]     req_base_addr;
    logic [I*L-1:0]   req_vector_data;
    logic [L-1:0]     req_scalar_data;
    logic             mem_ready;
    logic             mem_we;
    logic [A-1:0]     mem_addr;
    logic [L-1:0]     mem_wdata;
    logic             busy;
    logic             done;
    modport master (
        output req_valid, req_vector, req_base_addr, req_vector_data, req_scalar_data, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
    modport slave (
        input  req_valid, req_vector, req_base_addr, req_vector_data, req_scalar_data, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/vector_store_sequencer.sv
// vector_store_sequencer: sequences vector (I writes) and scalar (1 write) stores onto one memory write port
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   vector_store_sequencer_if.slave: request handshake, memory write port, busy, done
module vector_store_sequencer #(
    parameter int I = 20,
    parameter int L = 32,
    parameter int A = 10
) (
    input logic                       clk,
    input logic                       rst,
    vector_store_sequencer_if.slave   bus
);
    localparam int IW = (I > 1) ? $clog2(I) : 1;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    vec_q, vec_d;
    logic [A-1:0]            base_q, base_d;
    logic [I-1:0][L-1:0]     vdata_q, vdata_d;
    logic [L-1:0]            sdata_q, sdata_d;
    logic                    last;
    // a scalar store is always on its last (only) write
    assign last = !vec_q || idx_q == IW'(I - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= 1'b0;
            base_q  <= '0;
            vdata_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            base_q  <= base_d;
            vdata_q <= vdata_d;
            sdata_q <= sdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        base_d  = base_q;
        vdata_d = vdata_q;
        sdata_d = sdata_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = WRITE;
                idx_d   = '0;
                vec_d   = bus.req_vector;
                base_d  = bus.req_base_addr;
                vdata_d = bus.req_vector_data;
                sdata_d = bus.req_scalar_data;
            end
            WRITE: if (bus.mem_ready) begin
                state_d = last ? DONE : WRITE;
                idx_d   = last ? idx_q : idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs decode from state and latched operands only
    assign bus.req_ready = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.mem_we    = state_q == WRITE;
    assign bus.mem_addr  = bus.mem_we ? base_q + A'(idx_q) : '0;
    assign bus.mem_wdata = !bus.mem_we ? '0 : vec_q ? vdata_q[idx_q] : sdata_q;
endmodule

// File: tb/tb_vector_store_sequencer.sv
// tb_vector_store_sequencer: table-driven stores with a write scoreboard plus reset corner sequences
module tb_vector_store_sequencer;
    localparam int I = 20;
    localparam int L = 32;
    localparam int A = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    vector_store_sequencer_if #(.I(I), .L(L), .A(A)) bus ();
    vector_store_sequencer #(.I(I), .L(L), .A(A)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic [A-1:0] addr;
        logic [L-1:0] data;
    } wr_t;
    typedef struct {
        logic         vec;
        logic [A-1:0] base;
        logic [L-1:0] scalar;
        logic [L-1:0] seed;
        logic         stall;
        logic         pulse;
        int           exp_done;
    } row_t;
    wr_t  exp_q[$];
    row_t rows[5];
    int   checks = 0;
    int   errors = 0;
    logic         held = 1'b0;
    logic [A-1:0] h_addr;
    logic [L-1:0] h_data;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // scoreboard: every accepted write must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (held && bus.mem_we) begin
            chk("hold_addr", 64'(bus.mem_addr), 64'(h_addr));
            chk("hold_data", 64'(bus.mem_wdata), 64'(h_data));
        end
        held   = bus.mem_we && !bus.mem_ready && !rst;
        h_addr = bus.mem_addr;
        h_data = bus.mem_wdata;
        if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
            end
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic push_writes(input logic vec, input logic [A-1:0] base, input logic [L-1:0] sc,
                               input logic [L-1:0] seed, input int n);
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.addr = base + A'(k);
            w.data = vec ? seed + L'(k) : sc;
            exp_q.push_back(w);
        end
    endtask
    task automatic drive_req(input logic vec, input logic [A-1:0] base, input logic [L-1:0] sc,
                             input logic [L-1:0] seed);
        bus.req_vector      = vec;
        bus.req_base_addr   = base;
        bus.req_scalar_data = sc;
        for (int k = 0; k < I; k++) bus.req_vector_data[k*L +: L] = seed + L'(k);
        bus.req_valid = 1'b1;
    endtask
    task automatic scramble();
        bus.req_vector      = ~bus.req_vector;
        bus.req_base_addr   = ~bus.req_base_addr;
        bus.req_scalar_data = ~bus.req_scalar_data;
        bus.req_vector_data = ~bus.req_vector_data;
    endtask
    task automatic do_store(input row_t r);
        int done_c = -1;
        push_writes(r.vec, r.base, r.scalar, r.seed, r.vec ? I : 1);
        drive_req(r.vec, r.base, r.scalar, r.seed);
        cyc();
        bus.req_valid = 1'b0;
        scramble();
        chk("busy_after_accept", 64'(bus.busy), 64'(1));
        chk("ready_after_accept", 64'(bus.req_ready), 64'(0));
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            bus.mem_ready = !(r.stall && (c inside {[1:3], [11:13]}));
            bus.req_valid = r.pulse && c == 5;
            @(negedge clk);
            if (bus.done === 1'b1) done_c = c;
            if (done_c < 0) cyc();
        end
        chk("done_cycle", 64'(done_c), 64'(r.exp_done));
        bus.mem_ready = 1'b1;
        bus.req_valid = 1'b0;
        cyc();
        chk("done_one_cycle", 64'(bus.done), 64'(0));
        chk("ready_after_done", 64'(bus.req_ready), 64'(1));
        chk("idle_after_done", 64'(bus.busy), 64'(0));
        chk("all_writes_seen", 64'(exp_q.size()), 64'(0));
    endtask
    initial begin
        rows[0] = '{vec: 1'b0, base: 10'h012, scalar: 32'hDEADBEEF, seed: 32'd0,      stall: 1'b0, pulse: 1'b0, exp_done: 2};
        rows[1] = '{vec: 1'b1, base: 10'd100, scalar: 32'h0,        seed: 32'd1,      stall: 1'b0, pulse: 1'b0, exp_done: 21};
        rows[2] = '{vec: 1'b1, base: 10'd200, scalar: 32'h0,        seed: 32'd1,      stall: 1'b1, pulse: 1'b0, exp_done: 27};
        rows[3] = '{vec: 1'b1, base: 10'd1021, scalar: 32'h0,       seed: 32'hA000,   stall: 1'b0, pulse: 1'b1, exp_done: 21};
        rows[4] = '{vec: 1'b0, base: 10'h3FF, scalar: 32'h12345678, seed: 32'd0,      stall: 1'b1, pulse: 1'b0, exp_done: 5};
        bus.req_valid       = 1'b0;
        bus.req_vector      = 1'b0;
        bus.req_base_addr   = '0;
        bus.req_scalar_data = '0;
        bus.req_vector_data = '0;
        bus.mem_ready       = 1'b1;
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst_ready", 64'(bus.req_ready), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_we", 64'(bus.mem_we), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst_wdata", 64'(bus.mem_wdata), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("idle_we", 64'(bus.mem_we), 64'(0));
            chk("idle_done", 64'(bus.done), 64'(0));
        end
        for (int k = 0; k < 5; k++) do_store(rows[k]);
        // reset in the same cycle as an otherwise-accepted request drops it
        drive_req(1'b1, 10'd50, 32'h0, 32'h77);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        chk("rst_accept_busy", 64'(bus.busy), 64'(0));
        chk("rst_accept_ready", 64'(bus.req_ready), 64'(1));
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_accept_no_we", 64'(bus.mem_we), 64'(0));
        end
        // reset after five writes of a vector store abandons the rest
        push_writes(1'b1, 10'd300, 32'h0, 32'h50, 5);
        drive_req(1'b1, 10'd300, 32'h0, 32'h50);
        cyc();
        bus.req_valid = 1'b0;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("abort_we", 64'(bus.mem_we), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_ready", 64'(bus.req_ready), 64'(1));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_writes", 64'(exp_q.size()), 64'(0));
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("abort_no_done", 64'(bus.done), 64'(0));
        end
        do_store(rows[0]);
        repeat (2) cyc();
        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
